// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/funct codes, latency defaults and sequencer state type
package alu_pkg;

    // Instruction class driven on sorf
    localparam logic [1:0] SORF_IMM     = 2'b00;
    localparam logic [1:0] SORF_SPECIAL = 2'b01;
    localparam logic [1:0] SORF_FPU     = 2'b10;

    // Integer opcodes of interest
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_IN   = 6'b111110;

    // FPU funct codes
    localparam logic [5:0] FN_FADD  = 6'b000000;
    localparam logic [5:0] FN_FSUB  = 6'b000001;
    localparam logic [5:0] FN_FMUL  = 6'b000010;
    localparam logic [5:0] FN_FSQRT = 6'b000100;

    // Default final latency-count values
    localparam int LAT_FADD_DEF  = 2;
    localparam int LAT_FSQRT_DEF = 4;

    // Latency counter saturates here rather than wrapping
    localparam logic [3:0] CNT_MAX = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXEC    = 2'd1,
        ST_WAIT_IN = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // IN is the only op that waits on the UART buffer instead of counting
    function automatic logic is_in_op(input logic [1:0] sorf, input logic [5:0] instr);
        return (sorf == SORF_IMM) && (instr == OP_IN);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - request, ALU-side and completion signals of the ALU sequencer
//
// Signals:
//   req_valid/req_ready/req_sorf/req_instr : issue handshake and request payload
//   flush                                   : abandon the current operation
//   alu_sorf/alu_instr/alu_latency          : class, opcode and latency count to the ALU
//   alu_is_in                               : one-cycle UART-buffer pop strobe
//   alu_in_valid/alu_d                      : ALU IN-ready flag and ALU result register
//   done/result/busy                        : completion pulse, captured result, activity flag
// Modports: slave = sequencer view, master = requester/ALU view.
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_sorf;
    logic [5:0]  req_instr;
    logic        flush;
    logic [1:0]  alu_sorf;
    logic [5:0]  alu_instr;
    logic [3:0]  alu_latency;
    logic        alu_is_in;
    logic        alu_in_valid;
    logic [31:0] alu_d;
    logic        done;
    logic [31:0] result;
    logic        busy;

    modport slave (
        input  req_valid, req_sorf, req_instr, flush, alu_in_valid, alu_d,
        output req_ready, alu_sorf, alu_instr, alu_latency, alu_is_in, done, result, busy
    );

    modport master (
        output req_valid, req_sorf, req_instr, flush, alu_in_valid, alu_d,
        input  req_ready, alu_sorf, alu_instr, alu_latency, alu_is_in, done, result, busy
    );
endinterface

// File: rtl/alu_lat_lut.sv
// rtl/alu_lat_lut.sv - combinational lookup of the final latency count for a class/opcode pair
//
// Ports:
//   i_sorf  : instruction class
//   i_instr : opcode or funct
//   o_lat   : final latency-count value L (0 for anything that is not a multi-cycle FPU op)
module alu_lat_lut
    import alu_pkg::*;
#(
    parameter int LAT_FADD  = LAT_FADD_DEF,
    parameter int LAT_FSQRT = LAT_FSQRT_DEF
) (
    input  logic [1:0] i_sorf,
    input  logic [5:0] i_instr,
    output logic [3:0] o_lat
);

    always_comb begin
        o_lat = 4'd0;
        if (i_sorf == SORF_FPU) begin
            case (i_instr)
                FN_FADD, FN_FSUB, FN_FMUL: o_lat = 4'(LAT_FADD);
                FN_FSQRT:                  o_lat = 4'(LAT_FSQRT);
                default:                   o_lat = 4'd0;
            endcase
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - issues one op at a time to the ALU, counts its latency and captures the result
//
// Ports:
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : alu_sequencer_if.slave (request handshake, ALU drive, completion)
// Parameters:
//   LAT_FADD  : final latency count for FPU add/sub/mul
//   LAT_FSQRT : final latency count for FPU sqrt
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int LAT_FADD  = LAT_FADD_DEF,
    parameter int LAT_FSQRT = LAT_FSQRT_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    alu_sequencer_if.slave  bus
);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [1:0]  r_sorf;
    logic [5:0]  r_instr;
    logic        r_done;
    logic [31:0] r_result;

    logic [3:0]  w_lat_final;
    logic        w_accept;
    logic        w_in_pop;
    logic        w_done_exit;

    alu_lat_lut #(
        .LAT_FADD  (LAT_FADD),
        .LAT_FSQRT (LAT_FSQRT)
    ) u_lat_lut (
        .i_sorf  (r_sorf),
        .i_instr (r_instr),
        .o_lat   (w_lat_final)
    );

    // A flush in IDLE blocks a same-cycle accept
    assign w_accept    = rstn && (r_state == ST_IDLE) && bus.req_valid && !bus.flush;
    // A flush in DONE suppresses both the done pulse and the result capture
    assign w_done_exit = (r_state == ST_DONE) && !bus.flush;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_pop     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = is_in_op(bus.req_sorf, bus.req_instr) ? ST_WAIT_IN : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.flush) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt == w_lat_final) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_WAIT_IN: begin
                // flush wins over alu_in_valid so the UART byte stays in the buffer
                if (bus.flush) begin
                    w_next_state = ST_IDLE;
                end else if (bus.alu_in_valid) begin
                    w_in_pop     = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt    <= 4'd0;
            r_sorf   <= 2'b00;
            r_instr  <= 6'b000000;
            r_done   <= 1'b0;
            r_result <= 32'd0;
        end else begin
            r_done <= w_done_exit;
            if (w_done_exit) begin
                r_result <= bus.alu_d;
            end

            if (w_accept) begin
                r_sorf  <= bus.req_sorf;
                r_instr <= bus.req_instr;
                r_cnt   <= 4'd0;
            end else if ((r_state == ST_EXEC) && !bus.flush &&
                         (r_cnt != w_lat_final) && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Outputs are gated with rstn so they read as reset values for the whole reset window
    assign bus.req_ready   = rstn && (r_state == ST_IDLE);
    assign bus.busy        = rstn && (r_state != ST_IDLE);
    assign bus.alu_is_in   = rstn && w_in_pop;
    assign bus.alu_sorf    = bus.busy ? r_sorf  : 2'b00;
    assign bus.alu_instr   = bus.busy ? r_instr : 6'b000000;
    assign bus.alu_latency = (rstn && ((r_state == ST_EXEC) || (r_state == ST_DONE))) ? r_cnt : 4'd0;
    assign bus.done        = r_done;
    assign bus.result      = r_result;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench for alu_sequencer
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   is_in_cnt = 0;

    typedef struct {
        logic [31:0] res;
        int          at_edge;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    alu_sequencer_if bus ();

    alu_sequencer #(
        .LAT_FADD  (2),
        .LAT_FSQRT (4)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse, counts IN strobes
    always @(negedge clk) begin
        if (bus.alu_is_in === 1'b1) is_in_cnt++;
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_edge", 32'(cyc), 32'(mon_e.at_edge));
                chk("result", bus.result, mon_e.res);
            end
        end
    end

    // All stimulus tasks start and end just after a rising edge
    task automatic issue(input logic [1:0] s, input logic [5:0] ins, input logic [31:0] d,
                         output int acc_edge);
        bus.req_valid = 1'b1;
        bus.req_sorf  = s;
        bus.req_instr = ins;
        bus.alu_d     = d;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        acc_edge = cyc;
        chk("accept_busy", 32'(bus.busy), 32'd1);
    endtask

    task automatic trace_lat(input int lat, input logic [5:0] ins);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk("alu_latency", 32'(bus.alu_latency), 32'(k));
            chk("alu_instr", 32'(bus.alu_instr), 32'(ins));
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy !== 1'b0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_op(input logic [1:0] s, input logic [5:0] ins, input int lat,
                          input logic [31:0] d);
        int e;
        exp_t x;
        issue(s, ins, d, e);
        x.res = d;
        x.at_edge = e + lat + 2;
        exp_q.push_back(x);
        // issue already consumed the accept edge; rewind the phase to trace from cnt=0
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk("alu_latency", 32'(bus.alu_latency), 32'(k));
            chk("alu_sorf", 32'(bus.alu_sorf), 32'(s));
            if (k < lat) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        wait_idle();
    endtask

    initial begin
        int   e;
        int   in_before;
        exp_t x;

        rstn             = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_sorf     = 2'b00;
        bus.req_instr    = 6'b000000;
        bus.flush        = 1'b0;
        bus.alu_in_valid = 1'b0;
        bus.alu_d        = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_alu_is_in", 32'(bus.alu_is_in), 32'd0);
        chk("rst_alu_latency", 32'(bus.alu_latency), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // ADDI, FADD, FSQRT with hand-computed latencies 0/2/4
        run_op(SORF_IMM, OP_ADDI,  0, 32'hDEADBEEF);
        run_op(SORF_FPU, FN_FADD,  2, 32'h3F800000);
        run_op(SORF_FPU, FN_FSQRT, 4, 32'h40000000);
        @(negedge clk);
        chk("idle_alu_sorf", 32'(bus.alu_sorf), 32'd0);
        chk("idle_alu_instr", 32'(bus.alu_instr), 32'd0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;

        // IN: wait 10 cycles with alu_in_valid low, then one pop
        in_before = is_in_cnt;
        issue(SORF_IMM, OP_IN, 32'h00000041, e);
        repeat (10) begin
            @(negedge clk);
            chk("in_wait_busy", 32'(bus.busy), 32'd1);
            chk("in_wait_instr", 32'(bus.alu_instr), 32'(OP_IN));
            @(posedge clk); #1;
        end
        bus.alu_in_valid = 1'b1;
        x.res = 32'h00000041;
        x.at_edge = cyc + 2;
        exp_q.push_back(x);
        @(posedge clk); #1;
        wait_idle();
        bus.alu_in_valid = 1'b0;
        @(negedge clk);
        chk("in_pop_count", 32'(is_in_cnt - in_before), 32'd1);
        @(posedge clk); #1;

        // Flush FMUL at cnt=1
        issue(SORF_FPU, FN_FMUL, 32'hBADBAD00, e);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_lat_at1", 32'(bus.alu_latency), 32'd1);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_idle", 32'(bus.busy), 32'd0);
        repeat (4) begin
            @(negedge clk);
            chk("flush_lat_zero", 32'(bus.alu_latency), 32'd0);
            chk("flush_result_kept", bus.result, 32'h00000041);
        end
        @(posedge clk); #1;

        // Back-to-back: second request held high through the done cycle
        issue(SORF_IMM, OP_ADDI, 32'h00000011, e);
        x.res = 32'h00000011;
        x.at_edge = e + 2;
        exp_q.push_back(x);
        bus.req_valid = 1'b1;
        bus.req_sorf  = SORF_FPU;
        bus.req_instr = FN_FADD;
        repeat (2) @(posedge clk);
        #1;
        bus.alu_d = 32'h00000022;
        @(negedge clk);
        chk("b2b_ready_in_done", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("b2b_accept_busy", 32'(bus.busy), 32'd1);
        chk("b2b_accept_edge", 32'(cyc), 32'(e + 3));
        x.res = 32'h00000022;
        x.at_edge = e + 3 + 4;
        exp_q.push_back(x);
        wait_idle();
        @(posedge clk); #1;

        // Flush in IDLE with req_valid: no accept
        bus.req_valid = 1'b1;
        bus.req_sorf  = SORF_IMM;
        bus.req_instr = OP_ADDI;
        bus.flush     = 1'b1;
        @(posedge clk); #1;
        chk("idle_flush_no_accept", 32'(bus.busy), 32'd0);
        bus.req_valid = 1'b0;
        bus.flush     = 1'b0;

        // Reset during WAIT_IN
        in_before = is_in_cnt;
        issue(SORF_IMM, OP_IN, 32'h00000099, e);
        @(posedge clk); #1;
        rstn = 1'b0;
        bus.alu_in_valid = 1'b1;
        @(negedge clk);
        chk("rstw_alu_is_in", 32'(bus.alu_is_in), 32'd0);
        chk("rstw_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rstw_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_result", bus.result, 32'd0);
        chk("rstw_done", 32'(bus.done), 32'd0);
        chk("rstw_alu_sorf", 32'(bus.alu_sorf), 32'd0);
        chk("rstw_alu_latency", 32'(bus.alu_latency), 32'd0);
        @(posedge clk); #1;
        bus.alu_in_valid = 1'b0;
        rstn = 1'b1;
        chk("rstw_no_pop", 32'(is_in_cnt - in_before), 32'd0);

        // First accept on the first edge after reset release
        run_op(SORF_IMM, OP_ADDI, 0, 32'h00000055);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("total_in_pops", 32'(is_in_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter LAT_FADD, default 2: final latency-count value for FPU add/sub/mul.
REQ-002 SHALL have parameter LAT_FSQRT, default 4: final latency-count value for FPU sqrt.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  issue request.
REQ-006 SHALL have port req_ready  output  1  sequencer can accept a request.
REQ-007 SHALL have port req_sorf  input  2  class: 00 immediate/other, 01 special, 10 FPU.
REQ-008 SHALL have port req_instr  input  6  opcode or funct.
REQ-009 SHALL have port flush  input  1  abandon current operation.
REQ-010 SHALL have ports alu_sorf (output, 2) and alu_instr (output, 6): class and opcode driven to the ALU.
REQ-011 SHALL have port alu_latency  output  4  latency count to the ALU.
REQ-012 SHALL have port alu_is_in  output  1  one-cycle UART-buffer pop strobe.
REQ-013 SHALL have ports alu_in_valid (input, 1) and alu_d (input, 32): ALU IN-ready flag and ALU result register.
REQ-014 SHALL have ports done (output, 1: one-cycle completion pulse), result (output, 32: captured result) and busy (output, 1: state != IDLE).

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, WAIT_IN, DONE; req_ready = (state == IDLE).
REQ-016 SHALL, on the edge where req_valid && req_ready, latch sorf/instr; go to WAIT_IN if sorf=00 and instr=111110 (IN), else to EXEC with cnt=0.
REQ-017 SHALL derive final count L: sorf=10 with instr 000000/000001/000010 -> LAT_FADD; sorf=10 with 000100 -> LAT_FSQRT; all others, including sorf=11, -> 0.
REQ-018 SHALL in EXEC drive alu_latency=cnt, increment cnt each cycle, and go to DONE on the edge where cnt==L.
REQ-019 SHALL in WAIT_IN hold the IN opcode, wait indefinitely, and, in the first cycle alu_in_valid=1, assert alu_is_in for exactly that cycle and go to DONE.
REQ-020 SHALL hold latched sorf/instr on alu_sorf/alu_instr in EXEC, WAIT_IN and DONE; in IDLE drive alu_sorf=00, alu_instr=000000, alu_latency=0.
REQ-021 SHALL stay in DONE exactly one cycle, then on its exit edge load result<=alu_d, set done=1 for one cycle, and return to IDLE.
REQ-022 SHALL make done visible L+2 cycles after the accept edge for non-IN ops (0-lat op: +2; fadd: +4; fsqrt: +6).
REQ-023 SHALL allow a new accept in the IDLE cycle where done=1 (back-to-back throughput: one op per L+3 cycles).
REQ-024 SHALL, on flush in any non-IDLE state, go to IDLE next edge with no done pulse and result unchanged; flush outranks alu_in_valid, so no alu_is_in and the byte is not consumed.
REQ-025 SHALL ignore flush in IDLE, and a simultaneous req_valid does not accept.
REQ-026 SHALL saturate cnt at 15 and never wrap.

Reset
REQ-027 SHALL while rstn=0 set state=IDLE, cnt=0, done=0, result=0, alu_is_in=0, busy=0, req_ready=0.
REQ-028 SHALL let reset asserted mid-operation abort the operation with no done pulse; first accept is possible on the first edge after rstn=1.

Structure
REQ-029 SHALL place opcode/funct/FPU codes, latency defaults and the state enum in shared package alu_pkg.
REQ-030 SHALL implement the L lookup as combinational sub-module alu_lat_lut (inputs sorf/instr, output 4-bit L).

Verification
REQ-031 SHALL cover: ADDI (00/001000) accepted at edge 0 -> alu_latency=0, done at edge 2, result=alu_d.
REQ-032 SHALL cover: FPU ADD (10/000000) -> alu_latency 0,1,2 on consecutive cycles, done at edge 4; FSQRT -> 0..4, done at edge 6.
REQ-033 SHALL cover: IN with alu_in_valid held low 10 cycles then high -> exactly one alu_is_in pulse, done 2 edges later, result=alu_d (e.g. 0x00000041).
REQ-034 SHALL cover: flush in EXEC cnt=1 of FMUL -> IDLE next edge, no done, alu_latency never reaches 2.
REQ-035 SHALL cover: second req_valid held high during done cycle -> accepted that cycle; rstn=0 during WAIT_IN -> all outputs at reset values, no alu_is_in.
